// File: rtl/arp_eth_tx.sv
// arp_eth_tx: turns a parallel ARP frame description into an Ethernet
// header beat plus an AXI-stream payload carrying the 28-byte ARP body.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   s_frame_valid/ready          frame input handshake (ready is registered)
//   s_eth_*, s_arp_*             header and ARP fields, latched on accept
//   m_eth_hdr_valid/ready        Ethernet header handshake
//   m_eth_dest_mac/src_mac/type  registered header fields
//   m_eth_payload_axis_*         ARP payload stream, byte 0 in lane 0
//   busy                         high while payload words remain
//
// Build option: define ARP_TX_PAD_EN to zero-pad the payload to the 46-byte
// Ethernet minimum; otherwise exactly 28 bytes are sent.
module arp_eth_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_frame_valid,
  output logic                  s_frame_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [15:0]           s_arp_htype,
  input  logic [15:0]           s_arp_ptype,
  input  logic [15:0]           s_arp_oper,
  input  logic [47:0]           s_arp_sha,
  input  logic [31:0]           s_arp_spa,
  input  logic [47:0]           s_arp_tha,
  input  logic [31:0]           s_arp_tpa,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy
);

`ifdef ARP_TX_PAD_EN
  localparam int LEN = 46;
`else
  localparam int LEN = 28;
`endif
  localparam int WORDS      = (LEN + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int BUF_W      = WORDS * DATA_WIDTH;
  localparam int PW         = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LAST_LANES = (LEN - 1) % KEEP_WIDTH + 1;
  localparam logic [KEEP_WIDTH-1:0] FULL_KEEP = '1;
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP =
    (KEEP_ENABLE != 0) ? (FULL_KEEP >> (KEEP_WIDTH - LAST_LANES)) : FULL_KEEP;
  localparam logic [PW-1:0] LAST_PTR = PW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HDR} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d, ptr_nxt;
  logic [BUF_W-1:0]      frame_q, frame_d, new_buf;
  logic                  ready_q, ready_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic [47:0]           dest_q, dest_d, src_q, src_d;
  logic [15:0]           type_q, type_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [223:0]          arp_msb;

  // ARP body MSB-first, then byte-reversed so payload byte i sits at [i*8+:8].
  // Bytes beyond the ARP body (padding and unused last-word lanes) stay zero.
  always_comb begin
    arp_msb = {s_arp_htype, s_arp_ptype, 8'd6, 8'd4, s_arp_oper,
               s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa};
    new_buf = '0;
    for (int i = 0; i < 28; i++) new_buf[i*8 +: 8] = arp_msb[(27-i)*8 +: 8];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    frame_d     = frame_q;
    ready_d     = ready_q;
    hdr_valid_d = hdr_valid_q;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    ptr_nxt     = ptr_q + 1'b1;

    if (hdr_valid_q && m_eth_hdr_ready) hdr_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // IDLE is only entered once the previous header has been taken.
        ready_d = 1'b1;
        if (s_frame_valid && ready_q) begin
          ready_d     = 1'b0;
          frame_d     = new_buf;
          dest_d      = s_eth_dest_mac;
          src_d       = s_eth_src_mac;
          type_d      = s_eth_type;
          hdr_valid_d = 1'b1;
          tvalid_d    = 1'b1;
          ptr_d       = '0;
          tdata_d     = new_buf[DATA_WIDTH-1:0];
          tlast_d     = (WORDS == 1);
          tkeep_d     = (WORDS == 1) ? LAST_KEEP : FULL_KEEP;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (tvalid_q && m_eth_payload_axis_tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            ptr_d    = '0;
            if (!hdr_valid_q || m_eth_hdr_ready) begin
              state_d = IDLE;
              ready_d = 1'b1;
            end else begin
              state_d = WAIT_HDR;
            end
          end else begin
            ptr_d   = ptr_nxt;
            tdata_d = frame_q[ptr_nxt*DATA_WIDTH +: DATA_WIDTH];
            tlast_d = (ptr_nxt == LAST_PTR);
            tkeep_d = (ptr_nxt == LAST_PTR) ? LAST_KEEP : FULL_KEEP;
          end
        end
      end
      WAIT_HDR: begin
        if (m_eth_hdr_ready) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      frame_q     <= '0;
      ready_q     <= 1'b0;
      hdr_valid_q <= 1'b0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      frame_q     <= frame_d;
      ready_q     <= ready_d;
      hdr_valid_q <= hdr_valid_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign s_frame_ready             = ready_q;
  assign m_eth_hdr_valid           = hdr_valid_q;
  assign m_eth_dest_mac            = dest_q;
  assign m_eth_src_mac             = src_q;
  assign m_eth_type                = type_q;
  assign m_eth_payload_axis_tdata  = tdata_q;
  assign m_eth_payload_axis_tkeep  = tkeep_q;
  assign m_eth_payload_axis_tvalid = tvalid_q;
  assign m_eth_payload_axis_tlast  = tlast_q;
  assign m_eth_payload_axis_tuser  = 1'b0;
  assign busy                      = tvalid_q;

endmodule

// File: tb/tb_arp_eth_tx.sv
module tb_arp_eth_tx;
`ifdef ARP_TX_PAD_EN
  localparam int LEN = 46;
`else
  localparam int LEN = 28;
`endif
  localparam int W64 = (LEN + 7) / 8;
  localparam logic [7:0] LASTK64 = 8'((1 << ((LEN - 1) % 8 + 1)) - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [47:0] dest = 48'hFFFF_FFFF_FFFF, src = 48'h0200_0000_0001, sha = 48'h0200_0000_0001;
  logic [47:0] tha = 48'h0;
  logic [15:0] etype = 16'h0806, htype = 16'h0001, ptype = 16'h0800, oper = 16'h0001;
  logic [31:0] spa = 32'hC0A8_0001, tpa = 32'hC0A8_0002;

  // byte-wide instance
  logic v8 = 0, r8, hv8, hr8 = 0, tv8, tr8 = 0, tl8, tu8, busy8;
  logic [47:0] dm8, sm8; logic [15:0] ty8; logic [7:0] td8; logic [0:0] tk8;
  // 64-bit instance
  logic v64 = 0, r64, hv64, hr64 = 1, tv64, tr64 = 1, tl64, tu64, busy64;
  logic [47:0] dm64, sm64; logic [15:0] ty64; logic [63:0] td64; logic [7:0] tk64;

  arp_eth_tx #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .s_frame_valid(v8), .s_frame_ready(r8),
    .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
    .s_arp_htype(htype), .s_arp_ptype(ptype), .s_arp_oper(oper),
    .s_arp_sha(sha), .s_arp_spa(spa), .s_arp_tha(tha), .s_arp_tpa(tpa),
    .m_eth_hdr_valid(hv8), .m_eth_hdr_ready(hr8),
    .m_eth_dest_mac(dm8), .m_eth_src_mac(sm8), .m_eth_type(ty8),
    .m_eth_payload_axis_tdata(td8), .m_eth_payload_axis_tkeep(tk8),
    .m_eth_payload_axis_tvalid(tv8), .m_eth_payload_axis_tready(tr8),
    .m_eth_payload_axis_tlast(tl8), .m_eth_payload_axis_tuser(tu8), .busy(busy8));

  arp_eth_tx #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .s_frame_valid(v64), .s_frame_ready(r64),
    .s_eth_dest_mac(dest), .s_eth_src_mac(src), .s_eth_type(etype),
    .s_arp_htype(htype), .s_arp_ptype(ptype), .s_arp_oper(oper),
    .s_arp_sha(sha), .s_arp_spa(spa), .s_arp_tha(tha), .s_arp_tpa(tpa),
    .m_eth_hdr_valid(hv64), .m_eth_hdr_ready(hr64),
    .m_eth_dest_mac(dm64), .m_eth_src_mac(sm64), .m_eth_type(ty64),
    .m_eth_payload_axis_tdata(td64), .m_eth_payload_axis_tkeep(tk64),
    .m_eth_payload_axis_tvalid(tv64), .m_eth_payload_axis_tready(tr64),
    .m_eth_payload_axis_tlast(tl64), .m_eth_payload_axis_tuser(tu64), .busy(busy64));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Hand-written expected payload for the fixed test frame; zero past byte 27.
  function automatic logic [7:0] expb(input int i);
    logic [223:0] v;
    v = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h0200_0000_0001,
         32'hC0A8_0001, 48'h0, 32'hC0A8_0002};
    if (i < 28) return v[(27-i)*8 +: 8];
    return 8'h00;
  endfunction

  task automatic wait_ready8();
    int w = 0;
    while (!r8 && w < 100) begin step(); w++; end
    if (w >= 100) chk("ready8_timeout", 64'(r8), 64'd1);
  endtask

  task automatic run8(input bit bp, input int hdr_hold);
    int k = 0, cyc = 0;
    bit hdr_pend = 1;
    v8 = 1; hr8 = 0; tr8 = 1;
    wait_ready8();
    step(); v8 = 0;
    chk("hdr_valid_n1", 64'(hv8), 64'd1);
    chk("tvalid_n1", 64'(tv8), 64'd1);
    chk("hdr_dest", 64'(dm8), 64'(48'hFFFF_FFFF_FFFF));
    chk("hdr_type", 64'(ty8), 64'h0806);
    while ((k < LEN || hdr_pend) && cyc < 2000) begin
      tr8 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hr8 = (cyc >= hdr_hold);
      if (hdr_pend && k == LEN) chk("ready_low_hdr_pend", 64'(r8), 64'd0);
      if (hv8 && hr8) hdr_pend = 0;
      if (tv8 && tr8) begin
        chk($sformatf("byte%0d", k), 64'(td8), 64'(expb(k)));
        chk($sformatf("tlast%0d", k), 64'(tl8), 64'(k == LEN - 1));
        if (k == 0) chk("tkeep8", 64'(tk8), 64'd1);
        chk("tuser8", 64'(tu8), 64'd0);
        k++;
      end
      step(); cyc++;
    end
    if (cyc >= 2000) chk("run8_timeout", 64'(cyc), 64'd0);
    tr8 = 1;
    chk("tvalid_after_last", 64'(tv8), 64'd0);
    chk("busy_after_last", 64'(busy8), 64'd0);
    chk("ready_after_done", 64'(r8), 64'd1);
  endtask

  initial begin
    int acc, n, last0, first1, w;
    logic [63:0] ew;
    // reset state
    rst = 1; step(); step(); step();
    chk("rst_ready", 64'(r8), 64'd0);
    chk("rst_hdr_valid", 64'(hv8), 64'd0);
    chk("rst_tvalid", 64'(tv8), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_tdata64", td64, 64'd0);
    chk("rst_tkeep64", 64'(tk64), 64'd0);
    rst = 0;
    chk("ready_first_cycle", 64'(r8), 64'd0);
    step();
    chk("ready_second_cycle", 64'(r8), 64'd1);

    run8(0, 0);   // plain frame, all readies high
    run8(1, 40);  // random back-pressure, header held off
    run8(0, 40);  // payload finishes long before header is taken

    // back-to-back frames
    v8 = 1; tr8 = 1; hr8 = 1; acc = 0; n = 0; last0 = -1; first1 = -1;
    for (int cyc = 0; cyc < 300 && n < 2 * LEN; cyc++) begin
      if (v8 && r8) acc++;
      if (tv8) begin
        chk($sformatf("b2b_byte%0d", n), 64'(td8), 64'(expb(n % LEN)));
        if (n == LEN - 1) last0 = cyc;
        if (n == LEN) first1 = cyc;
        n++;
      end
      step();
      if (acc == 2) v8 = 0;
    end
    v8 = 0;
    chk("b2b_gap", 64'(first1 - last0), 64'd2);
    step(); step();

    // reset in the middle of a frame
    v8 = 1; wait_ready8(); step(); v8 = 0; tr8 = 1; hr8 = 0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_tvalid_before", 64'(tv8), 64'd1);
    chk("mid_byte10", 64'(td8), 64'(expb(10)));
    rst = 1; step(); rst = 0;
    chk("mid_rst_tvalid", 64'(tv8), 64'd0);
    chk("mid_rst_hdr_valid", 64'(hv8), 64'd0);
    chk("mid_rst_busy", 64'(busy8), 64'd0);
    chk("mid_rst_tlast", 64'(tl8), 64'd0);
    chk("mid_rst_ready0", 64'(r8), 64'd0);
    step();
    chk("mid_rst_ready1", 64'(r8), 64'd1);
    run8(0, 0);

    // 64-bit bus
    v64 = 1; w = 0;
    while (!r64 && w < 100) begin step(); w++; end
    step(); v64 = 0;
    chk("hdr_valid64", 64'(hv64), 64'd1);
    n = 0;
    for (int cyc = 0; cyc < 100 && n < W64; cyc++) begin
      if (tv64) begin
        for (int b = 0; b < 8; b++) ew[b*8 +: 8] = expb(n * 8 + b);
        chk($sformatf("word64_%0d", n), td64, ew);
        chk($sformatf("tkeep64_%0d", n), 64'(tk64), 64'((n == W64 - 1) ? LASTK64 : 8'hFF));
        chk($sformatf("tlast64_%0d", n), 64'(tl64), 64'(n == W64 - 1));
        n++;
      end
      step();
    end
    chk("words64", 64'(n), 64'(W64));
    chk("tvalid64_after", 64'(tv64), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
